// File: rtl/max_of_stream_if.sv
// Valid/ready sample stream in, valid/ready frame result out, for max_of_stream.
// Optional min result signals exist when MAX_OF_STREAM_MIN_EN is defined.
interface max_of_stream_if #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [IDX_W-1:0] out_idx;
   logic             busy;
`ifdef MAX_OF_STREAM_MIN_EN
   logic [WIDTH-1:0] out_min;
   logic [IDX_W-1:0] out_min_idx;
`endif

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_max, out_idx, busy
`ifdef MAX_OF_STREAM_MIN_EN
      , output out_min, out_min_idx
`endif
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_max, out_idx, busy
`ifdef MAX_OF_STREAM_MIN_EN
      , input out_min, out_min_idx
`endif
   );
endinterface

// File: rtl/max_of_stream.sv
// Frame-wise maximum (and first-occurrence index) of an unsigned sample stream.
// Define MAX_OF_STREAM_MIN_EN to also track the frame minimum.
module max_of_stream #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   parameter int IDX_W     = 2
) (
   input logic             clk,
   input logic             rst,
   max_of_stream_if.slave  bus
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] count;
   logic [WIDTH-1:0] run_max, cand_max;
   logic [IDX_W-1:0] run_idx, cand_idx;
   logic [WIDTH-1:0] res_max;
   logic [IDX_W-1:0] res_idx;
   logic             accept, last;

   assign accept = (state == COLLECT) && bus.in_valid;
   assign last   = accept && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         COLLECT: begin
            bus.in_ready = 1'b1;
            bus.busy     = (count != '0);
            if (last) state_nxt = HOLD;
         end
         HOLD: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   // First sample seeds the running value; later ones replace it only when strictly larger.
   always_comb begin
      cand_max = run_max;
      cand_idx = run_idx;
      if (count == '0) begin
         cand_max = bus.in_data;
         cand_idx = '0;
      end else if (bus.in_data > run_max) begin
         cand_max = bus.in_data;
         cand_idx = count;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         run_max <= '0;
         run_idx <= '0;
         res_max <= '0;
         res_idx <= '0;
      end else if (accept) begin
         run_max <= cand_max;
         run_idx <= cand_idx;
         if (last) begin
            count   <= '0;
            res_max <= cand_max;
            res_idx <= cand_idx;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign bus.out_max = res_max;
   assign bus.out_idx = res_idx;

`ifdef MAX_OF_STREAM_MIN_EN
   logic [WIDTH-1:0] run_min, cand_min, res_min;
   logic [IDX_W-1:0] run_min_idx, cand_min_idx, res_min_idx;

   always_comb begin
      cand_min     = run_min;
      cand_min_idx = run_min_idx;
      if (count == '0) begin
         cand_min     = bus.in_data;
         cand_min_idx = '0;
      end else if (bus.in_data < run_min) begin
         cand_min     = bus.in_data;
         cand_min_idx = count;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_min     <= '0;
         run_min_idx <= '0;
         res_min     <= '0;
         res_min_idx <= '0;
      end else if (accept) begin
         run_min     <= cand_min;
         run_min_idx <= cand_min_idx;
         if (last) begin
            res_min     <= cand_min;
            res_min_idx <= cand_min_idx;
         end
      end
   end

   assign bus.out_min     = res_min;
   assign bus.out_min_idx = res_min_idx;
`endif
endmodule

// File: tb/tb_max_of_stream.sv
// Self-checking bench for max_of_stream: table-driven frames, scoreboard of
// expected results, and hand-written sequences for backpressure, gaps and reset.
module tb_max_of_stream;
   localparam int WIDTH = 8;
   localparam int FLEN  = 4;
   localparam int IDX_W = 2;
   localparam int LIMIT = 100;

   typedef struct packed {
      logic [FLEN-1:0][WIDTH-1:0] s;
      logic [WIDTH-1:0]           mx;
      logic [IDX_W-1:0]           ix;
      logic [WIDTH-1:0]           mn;
      logic [IDX_W-1:0]           mi;
   } frame_t;

   typedef struct packed {
      logic [WIDTH-1:0] mx;
      logic [IDX_W-1:0] ix;
      logic [WIDTH-1:0] mn;
      logic [IDX_W-1:0] mi;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   cyc = 0;
   res_t sb[$];
   int   res_cyc[$];
   frame_t tbl[8];

   max_of_stream_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();
   max_of_stream #(.WIDTH(WIDTH), .FRAME_LEN(FLEN), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic frame_t mk(input logic [7:0] a, b, c, d, mx, input int ix,
                                 input logic [7:0] mn, input int mi);
      frame_t f;
      f.s[0] = a; f.s[1] = b; f.s[2] = c; f.s[3] = d;
      f.mx = mx; f.ix = IDX_W'(ix); f.mn = mn; f.mi = IDX_W'(mi);
      return f;
   endfunction

   function automatic res_t model(input frame_t f);
      res_t r;
      r.mx = f.s[0]; r.ix = '0; r.mn = f.s[0]; r.mi = '0;
      for (int i = 1; i < FLEN; i++) begin
         if (f.s[i] > r.mx) begin r.mx = f.s[i]; r.ix = IDX_W'(i); end
         if (f.s[i] < r.mn) begin r.mn = f.s[i]; r.mi = IDX_W'(i); end
      end
      return r;
   endfunction

   function automatic res_t of_table(input frame_t f);
      res_t r;
      r.mx = f.mx; r.ix = f.ix; r.mn = f.mn; r.mi = f.mi;
      return r;
   endfunction

   // Scoreboard: every completed output handshake pops one expected result.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         res_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_result: got max 0x%0h idx %0d, expected no result",
                     bus.out_max, bus.out_idx);
         end else begin
            res_t e;
            e = sb.pop_front();
            chk("sb_out_max", 32'(bus.out_max), 32'(e.mx));
            chk("sb_out_idx", 32'(bus.out_idx), 32'(e.ix));
`ifdef MAX_OF_STREAM_MIN_EN
            chk("sb_out_min", 32'(bus.out_min), 32'(e.mn));
            chk("sb_out_min_idx", 32'(bus.out_min_idx), 32'(e.mi));
`endif
         end
      end
   end

   // Drive one sample and return 1 time unit after the edge that accepted it.
   task automatic send(input logic [7:0] d);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && t < LIMIT) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= LIMIT) begin
         total_cnt++;
         $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", t);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input frame_t f);
      for (int i = 0; i < FLEN; i++) send(f.s[i]);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < LIMIT) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      tbl[0] = mk(8'h10, 8'h40, 8'h05, 8'h22, 8'h40, 1, 8'h05, 2);
      tbl[1] = mk(8'h30, 8'h7F, 8'h12, 8'h7F, 8'h7F, 1, 8'h12, 2);
      tbl[2] = mk(8'h09, 8'h08, 8'h07, 8'h06, 8'h09, 0, 8'h06, 3);
      tbl[3] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
      tbl[4] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 8'hFF, 0);
      tbl[5] = mk(8'h01, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1, 8'h00, 2);
      tbl[6] = mk(8'h05, 8'h05, 8'h03, 8'h03, 8'h05, 0, 8'h03, 2);
      tbl[7] = mk(8'h20, 8'h21, 8'h22, 8'hFE, 8'hFE, 3, 8'h20, 0);

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_max", 32'(bus.out_max), 32'd0);
      chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef MAX_OF_STREAM_MIN_EN
      chk("rst_out_min", 32'(bus.out_min), 32'd0);
      chk("rst_out_min_idx", 32'(bus.out_min_idx), 32'd0);
`endif
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      // Back-to-back table frames with out_ready held high.
      res_cyc.delete();
      for (int k = 0; k < 8; k++) begin
         sb.push_back(of_table(tbl[k]));
         send_frame(tbl[k]);
         chk($sformatf("latency_out_valid_%0d", k), 32'(bus.out_valid), 32'd1);
      end
      drain();
      chk("b2b_result_count", 32'(res_cyc.size()), 32'd8);
      for (int i = 1; i < res_cyc.size(); i++)
         chk($sformatf("b2b_spacing_%0d", i), 32'(res_cyc[i] - res_cyc[i-1]), 32'(FLEN + 1));

      // Gaps inside a frame: running state and busy hold.
      sb.push_back(res_t'{mx: 8'hFF, ix: 2'd0, mn: 8'h00, mi: 2'd1});
      send(8'hFF);
      chk("gap_busy_a", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      chk("gap_busy_b", 32'(bus.busy), 32'd1);
      send(8'h00);
      @(posedge clk); #1;
      chk("gap_busy_c", 32'(bus.busy), 32'd1);
      send(8'h01);
      send(8'h02);
      chk("gap_busy_hold", 32'(bus.busy), 32'd0);
      drain();

      // Backpressure: result held while downstream stalls, next sample waits.
      bus.out_ready = 1'b0;
      sb.push_back(res_t'{mx: 8'h04, ix: 2'd3, mn: 8'h01, mi: 2'd0});
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_out_max", 32'(bus.out_max), 32'h04);
         chk("bp_out_idx", 32'(bus.out_idx), 32'd3);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_after_hs_in_ready", 32'(bus.in_ready), 32'd1);
      chk("bp_after_hs_out_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_after_hs_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp_next_accepted", 32'(bus.busy), 32'd1);
      sb.push_back(res_t'{mx: 8'h55, ix: 2'd0, mn: 8'h11, mi: 2'd3});
      send(8'h33); send(8'h44); send(8'h11);
      drain();

      // Reset mid-frame: partial frame discarded.
      send(8'h90); send(8'hA0);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk); rst = 1'b0;
      sb.push_back(res_t'{mx: 8'h04, ix: 2'd3, mn: 8'h01, mi: 2'd0});
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      drain();

      // Reset while holding a result: out_valid drops without a clock edge.
      bus.out_ready = 1'b0;
      send(8'h70); send(8'h71); send(8'h72); send(8'h73);
      chk("holdrst_pre_valid", 32'(bus.out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("holdrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("holdrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("holdrst_out_max", 32'(bus.out_max), 32'd0);
      @(negedge clk); rst = 1'b0;
      bus.out_ready = 1'b1;

      // Random frames with random idle cycles, checked against the model.
      for (int k = 0; k < 6; k++) begin
         frame_t f;
         f = '0;
         for (int i = 0; i < FLEN; i++) f.s[i] = 8'($urandom_range(0, 255));
         if (k == 0) f.s[2] = f.s[0];
         sb.push_back(model(f));
         for (int i = 0; i < FLEN; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(f.s[i]);
         end
      end
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/max_of_stream.md
Name: max_of_stream

Overview:
- Sequential counterpart to the four-input combinational minimum selector.
- Accepts unsigned byte samples serially over a valid/ready stream and, after FRAME_LEN samples, presents the maximum value and the index of its first occurrence on a valid/ready result port.
- Sits between the sample source and downstream selection logic that needs the extreme of each fixed-length frame, one frame at a time.

Parameters:
- WIDTH, 8: sample width in bits; comparisons are unsigned.
- FRAME_LEN, 4: samples per frame; legal range 2..256.
- IDX_W, 2: index width; must satisfy 2**IDX_W >= FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  unsigned sample.
- out_valid  output  1  frame result held on out_max/out_idx.
- out_ready  input  1  downstream accepts the result.
- out_max  output  WIDTH  largest sample of the completed frame.
- out_idx  output  IDX_W  position (0-based) of the first occurrence of out_max.
- busy  output  1  at least one sample of the current frame has been accepted.

Behaviour:
- Reset (async assert, sync release): state=COLLECT, count=0, running max=0, running idx=0.
  - Reset output values: in_ready=1, out_valid=0, out_max=0, out_idx=0, busy=0.
- States: COLLECT and HOLD.
- COLLECT:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid=1 in COLLECT.
  - On accept with count==0: running max := in_data, idx := 0.
  - On accept with count>0: if in_data > running max (strictly), max := in_data and idx := count; otherwise unchanged. Ties keep the earlier index.
  - count increments on each accept.
  - When the accepted sample is number FRAME_LEN-1 (0-based):
    - latch final max/idx into out_max/out_idx;
    - count := 0;
    - next state HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_max/out_idx stay stable until the handshake completes.
  - On out_valid&out_ready: next state COLLECT, out_valid drops the following cycle.
  - out_max/out_idx keep their last value after the handshake; they are don't-care when out_valid=0.
- Latency: out_valid rises the cycle after the last sample of the frame is accepted.
- Throughput: FRAME_LEN+1 cycles per frame minimum, when out_ready is held high.
- Backpressure: the source must hold in_data stable while in_valid=1 and in_ready=0. The block never drops or duplicates samples.
- in_valid gaps mid-frame: count and running state hold; there is no timeout.
- busy=1 when count!=0 in COLLECT; 0 otherwise.
- Reset mid-frame: the partial frame is discarded and the block returns to the reset values above.
- Reset in HOLD: the pending result is lost and out_valid deasserts asynchronously.
- All-equal frame: out_max = the common value, out_idx=0.
- Boundary values: all-zero frame gives out_max=0, idx=0; all-ones sample 0xFF is a legal max.

Optional Feature:
- Macro: MAX_OF_STREAM_MIN_EN.
- Defined:
  - Adds ports out_min (output, WIDTH) and out_min_idx (output, IDX_W).
  - Tracks the minimum concurrently using strictly-less replacement, so ties keep the earlier index.
  - Min outputs are latched and held with the same timing and handshake as out_max.
  - Reset value of both is 0.
- Not defined: ports and the min-tracking logic are absent; max behaviour is identical.

Test Plan:
- Reset release, stream 0x10,0x40,0x05,0x22 with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_max=0x40, out_idx=1; with MIN_EN, out_min=0x05, out_min_idx=2.
- Tie case 0x30,0x7F,0x12,0x7F -> out_max=0x7F, out_idx=1 (first occurrence).
- Backpressure: frame 1,2,3,4 then hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_max=4/idx=3 stable throughout; the next frame's first sample is accepted the cycle after the handshake.
- Gaps: samples 0xFF,_,_,0x00,_,0x01,0x02 with in_valid deasserted on gaps -> busy=1 during gaps, out_max=0xFF, out_idx=0.
- Reset asserted after 2 samples of a frame (0x90,0xA0), then full frame 0x01,0x02,0x03,0x04 -> out_max=0x04, out_idx=3; no result from the aborted frame.
- Back-to-back frames with out_ready=1: frames {9,8,7,6} and {0,0,0,0} -> results (9,0) then (0,0), each produced FRAME_LEN+1 cycles apart.
